// File: rtl/ml_kem_matgen_ctrl_if.sv
// Handshake bundle between the matrix-A sequencer, the mode controller,
// the shared SHAKE128 XOF and the polynomial RAM write port.
interface ml_kem_matgen_ctrl_if #(
   parameter int unsigned PIDX_W = 4
);
   logic                start_i;
   logic [2:0]          k_i;
   logic                transpose_i;
   logic                busy_o;
   logic                done_o;
   logic                xof_start_o;
   logic [7:0]          xof_b32_o;
   logic [7:0]          xof_b33_o;
   logic                xof_ack_i;
   logic                xof_valid_i;
   logic [23:0]         xof_data_i;
   logic                xof_ready_o;
   logic                xof_stop_o;
   logic                wr_en_o;
   logic [PIDX_W+7:0]   wr_addr_o;
   logic [11:0]         wr_data_o;

   modport master (
      input  start_i, k_i, transpose_i, xof_ack_i, xof_valid_i, xof_data_i,
      output busy_o, done_o, xof_start_o, xof_b32_o, xof_b33_o, xof_ready_o,
             xof_stop_o, wr_en_o, wr_addr_o, wr_data_o
   );

   modport slave (
      output start_i, k_i, transpose_i, xof_ack_i, xof_valid_i, xof_data_i,
      input  busy_o, done_o, xof_start_o, xof_b32_o, xof_b33_o, xof_ready_o,
             xof_stop_o, wr_en_o, wr_addr_o, wr_data_o
   );
endinterface

// File: rtl/ml_kem_matgen_ctrl.sv
// ML-KEM matrix A sequencer: seeds the XOF per polynomial, runs the SampleNTT
// rejection parse on 24-bit squeeze words and writes accepted coefficients.
module ml_kem_matgen_ctrl #(
   parameter int unsigned Q      = 3329,
   parameter int unsigned N      = 256,
   parameter int unsigned PIDX_W = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   ml_kem_matgen_ctrl_if.master bus
);
   localparam int unsigned CW     = $clog2(N);
   localparam logic [11:0] Q_C    = 12'(Q);
   localparam logic [CW:0] LAST_C = (CW+1)'(N - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SEED, S_SQUEEZE, S_FLUSH, S_NEXT, S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [2:0]           k_q, k_d;
   logic                 tr_q, tr_d;
   logic [1:0]           i_q, i_d, j_q, j_d;
   logic [PIDX_W-1:0]    poly_q, poly_d;
   logic [CW:0]          cnt_q, cnt_d;
   logic [11:0]          hold_q, hold_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 xstart_q, xstart_d;
   logic [7:0]           b32_q, b32_d, b33_q, b33_d;
   logic                 ready_q, ready_d;
   logic                 stop_q, stop_d;
   logic                 wr_en_q, wr_en_d;
   logic [PIDX_W+CW-1:0] wr_addr_q, wr_addr_d;
   logic [11:0]          wr_data_q, wr_data_d;

   logic [11:0] d1, d2;
   logic        acc1, acc2, hs, k_ok, last_j, last_poly;
   logic [1:0]  ni, nj;

   assign d1        = bus.xof_data_i[11:0];
   assign d2        = bus.xof_data_i[23:12];
   assign acc1      = d1 < Q_C;
   assign acc2      = d2 < Q_C;
   assign hs        = (state_q == S_SQUEEZE) && ready_q && bus.xof_valid_i;
   assign k_ok      = (bus.k_i >= 3'd2) && (bus.k_i <= 3'd4);
   assign last_j    = ({1'b0, j_q} == (k_q - 3'd1));
   assign last_poly = last_j && ({1'b0, i_q} == (k_q - 3'd1));
   assign nj        = last_j ? 2'd0 : j_q + 2'd1;
   assign ni        = last_j ? i_q + 2'd1 : i_q;

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      tr_d      = tr_q;
      i_d       = i_q;
      j_d       = j_q;
      poly_d    = poly_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      xstart_d  = xstart_q;
      b32_d     = b32_q;
      b33_d     = b33_q;
      ready_d   = ready_q;
      stop_d    = 1'b0;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start_i && k_ok) begin
               state_d  = S_SEED;
               k_d      = bus.k_i;
               tr_d     = bus.transpose_i;
               i_d      = '0;
               j_d      = '0;
               poly_d   = '0;
               cnt_d    = '0;
               hold_d   = '0;
               busy_d   = 1'b1;
               xstart_d = 1'b1;
               b32_d    = '0;
               b33_d    = '0;
            end
         end
         S_SEED: begin
            if (bus.xof_ack_i) begin
               state_d  = S_SQUEEZE;
               xstart_d = 1'b0;
               cnt_d    = '0;
               ready_d  = 1'b1;
            end
         end
         S_SQUEEZE: begin
            // d1 always takes the first free slot; d2 either writes directly
            // (d1 rejected) or parks in the hold register for FLUSH.
            if (hs && (acc1 || acc2)) begin
               wr_en_d   = 1'b1;
               wr_addr_d = {poly_q, cnt_q[CW-1:0]};
               wr_data_d = acc1 ? d1 : d2;
               cnt_d     = cnt_q + (CW+1)'(1);
               if (cnt_q == LAST_C) begin
                  state_d = S_NEXT;
                  ready_d = 1'b0;
                  stop_d  = 1'b1;
               end else if (acc1 && acc2) begin
                  hold_d  = d2;
                  state_d = S_FLUSH;
                  ready_d = 1'b0;
               end
            end
         end
         S_FLUSH: begin
            wr_en_d   = 1'b1;
            wr_addr_d = {poly_q, cnt_q[CW-1:0]};
            wr_data_d = hold_q;
            cnt_d     = cnt_q + (CW+1)'(1);
            hold_d    = '0;
            if (cnt_q == LAST_C) begin
               state_d = S_NEXT;
               stop_d  = 1'b1;
            end else begin
               state_d = S_SQUEEZE;
               ready_d = 1'b1;
            end
         end
         S_NEXT: begin
            i_d    = ni;
            j_d    = nj;
            poly_d = poly_q + PIDX_W'(1);
            if (last_poly) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               state_d  = S_SEED;
               xstart_d = 1'b1;
               b32_d    = tr_q ? {6'd0, ni} : {6'd0, nj};
               b33_d    = tr_q ? {6'd0, nj} : {6'd0, ni};
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         k_q       <= '0;
         tr_q      <= 1'b0;
         i_q       <= '0;
         j_q       <= '0;
         poly_q    <= '0;
         cnt_q     <= '0;
         hold_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         xstart_q  <= 1'b0;
         b32_q     <= '0;
         b33_q     <= '0;
         ready_q   <= 1'b0;
         stop_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         tr_q      <= tr_d;
         i_q       <= i_d;
         j_q       <= j_d;
         poly_q    <= poly_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         xstart_q  <= xstart_d;
         b32_q     <= b32_d;
         b33_q     <= b33_d;
         ready_q   <= ready_d;
         stop_q    <= stop_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign bus.busy_o      = busy_q;
   assign bus.done_o      = done_q;
   assign bus.xof_start_o = xstart_q;
   assign bus.xof_b32_o   = b32_q;
   assign bus.xof_b33_o   = b33_q;
   assign bus.xof_ready_o = ready_q;
   assign bus.xof_stop_o  = stop_q;
   assign bus.wr_en_o     = wr_en_q;
   assign bus.wr_addr_o   = wr_addr_q;
   assign bus.wr_data_o   = wr_data_q;
endmodule

// File: tb/tb_ml_kem_matgen_ctrl.sv
// Bench for ml_kem_matgen_ctrl: emulates the XOF, models SampleNTT per squeeze
// word, and scoreboards every RAM write plus seed bytes and pulse counts.
module tb_ml_kem_matgen_ctrl;
   typedef struct {
      logic [23:0] word;
      int unsigned nacc;
      logic [11:0] c0;
      logic [11:0] c1;
   } vec_t;

   typedef struct {
      logic [11:0] addr;
      logic [11:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ml_kem_matgen_ctrl_if #(.PIDX_W(4)) bus ();

   ml_kem_matgen_ctrl #(.Q(3329), .N(256), .PIDX_W(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   wr_t         exp_q[$];
   wr_t         wlog[$];
   logic [23:0] forced[$];
   int unsigned stop_cnt, done_cnt, acks, hs_count, k_run, stall_pct, ack_dly, mcnt, mpoly;
   logic        tr_run, auto_mode;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   task automatic fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   // SampleNTT on one squeeze word, straight from the byte formulas.
   task automatic model_word(input logic [23:0] w);
      int unsigned b0, b1, b2;
      int unsigned c[2];
      b0 = w[7:0];
      b1 = w[15:8];
      b2 = w[23:16];
      c[0] = b0 + 256 * (b1 % 16);
      c[1] = (b1 / 16) + 16 * b2;
      for (int n = 0; n < 2; n++) begin
         if (mcnt < 256 && c[n] < 3329) begin
            exp_q.push_back('{addr: 12'(mpoly * 256 + mcnt), data: 12'(c[n])});
            mcnt++;
         end
      end
   endtask

   task automatic tick();
      logic [23:0] w;
      wr_t         e;
      @(negedge clk);
      if (bus.wr_en_o) begin
         wlog.push_back('{addr: bus.wr_addr_o, data: bus.wr_data_o});
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                     bus.wr_addr_o, bus.wr_data_o);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", bus.wr_addr_o, e.addr);
            check("wr_data", bus.wr_data_o, e.data);
         end
      end
      if (bus.xof_stop_o) stop_cnt++;
      if (bus.done_o) begin
         done_cnt++;
         check("busy_at_done", bus.busy_o, 0);
      end
      if (bus.xof_start_o && !bus.xof_ack_i) begin
         if (ack_dly == 0) begin
            bus.xof_ack_i = 1'b1;
            check("seed_b32", bus.xof_b32_o, tr_run ? acks / k_run : acks % k_run);
            check("seed_b33", bus.xof_b33_o, tr_run ? acks % k_run : acks / k_run);
            mpoly   = acks;
            mcnt    = 0;
            acks++;
            ack_dly = $urandom_range(0, 3);
         end else begin
            ack_dly--;
         end
      end else begin
         bus.xof_ack_i = 1'b0;
      end
      if (auto_mode) begin
         bus.xof_valid_i = ($urandom_range(0, 99) >= stall_pct);
         w = (forced.size() != 0) ? forced[0] : 24'($urandom);
      end else begin
         bus.xof_valid_i = (forced.size() != 0);
         w = (forced.size() != 0) ? forced[0] : 24'h0;
      end
      bus.xof_data_i = w;
      if (bus.xof_valid_i && bus.xof_ready_o) begin
         model_word(w);
         hs_count++;
         if (forced.size() != 0) void'(forced.pop_front());
      end
   endtask

   task automatic start_run(input int unsigned k, input logic tr);
      k_run    = k;
      tr_run   = tr;
      acks     = 0;
      stop_cnt = 0;
      done_cnt = 0;
      wlog.delete();
      bus.k_i         = 3'(k);
      bus.transpose_i = tr;
      bus.start_i     = 1'b1;
      tick();
      bus.start_i = 1'b0;
      tick();
      check("busy_after_start", bus.busy_o, 1);
   endtask

   task automatic finish_run(input int unsigned k);
      int unsigned b;
      b = 0;
      while (done_cnt == 0 && b < 30000) begin
         tick();
         b++;
      end
      if (done_cnt == 0) fail("done_timeout");
      tick();
      tick();
      check("done_pulses", done_cnt, 1);
      check("stop_pulses", stop_cnt, k * k);
      check("write_count", wlog.size(), k * k * 256);
      if (wlog.size() != 0) check("last_addr", wlog[wlog.size()-1].addr, 12'(k * k * 256 - 1));
      check("busy_idle", bus.busy_o, 0);
      check("model_drained", exp_q.size(), 0);
   endtask

   initial begin
      vec_t        tbl[6];
      int unsigned n0, w0, b, nlog;

      tbl[0] = '{24'h8B5AAB, 2, 12'hAAB, 12'h8B5};
      tbl[1] = '{24'hFFFD01, 0, 12'h000, 12'h000};
      tbl[2] = '{24'h000D00, 2, 12'hD00, 12'h000};
      tbl[3] = '{24'h0FFFFF, 1, 12'h0FF, 12'h000};
      tbl[4] = '{24'hFFF123, 1, 12'h123, 12'h000};
      tbl[5] = '{24'hD01D00, 1, 12'hD00, 12'h000};

      rst = 1'b1;
      bus.start_i = 1'b0;
      bus.k_i = 3'd0;
      bus.transpose_i = 1'b0;
      bus.xof_ack_i = 1'b0;
      bus.xof_valid_i = 1'b0;
      bus.xof_data_i = '0;
      stop_cnt = 0; done_cnt = 0; acks = 0; hs_count = 0; k_run = 2;
      stall_pct = 0; ack_dly = 0; mcnt = 0; mpoly = 0;
      tr_run = 1'b0; auto_mode = 1'b0;

      tick();
      check("reset_outputs", {bus.busy_o, bus.done_o, bus.xof_start_o, bus.xof_b32_o,
                              bus.xof_b33_o, bus.xof_ready_o, bus.xof_stop_o, bus.wr_en_o,
                              bus.wr_addr_o, bus.wr_data_o}, 64'd0);
      tick();
      rst = 1'b0;
      tick();

      // Directed parse vectors within polynomial 0 of a k=2 run.
      start_run(2, 1'b0);
      foreach (tbl[v]) begin
         n0 = hs_count;
         w0 = wlog.size();
         forced.push_back(tbl[v].word);
         for (int t = 0; t < 20 && hs_count == n0; t++) tick();
         if (hs_count == n0) fail("tbl_handshake");
         tick();
         check("tbl_ready_t1", bus.xof_ready_o, (tbl[v].nacc == 2) ? 0 : 1);
         tick();
         check("tbl_ready_t2", bus.xof_ready_o, 1);
         check("tbl_nwrites", wlog.size() - w0, tbl[v].nacc);
         if (tbl[v].nacc >= 1 && wlog.size() > w0) check("tbl_c0", wlog[w0].data, tbl[v].c0);
         if (tbl[v].nacc == 2 && wlog.size() > w0 + 1) check("tbl_c1", wlog[w0+1].data, tbl[v].c1);
      end
      if (wlog.size() >= 2) check("tbl_first_addrs", {wlog[0].addr, wlog[1].addr}, {12'h000, 12'h001});
      auto_mode = 1'b1;
      stall_pct = 20;
      finish_run(2);

      // Coefficient 254/255 boundary: poly 0 ends via FLUSH, poly 1 drops d2 at idx 255.
      auto_mode = 1'b0;
      repeat (127) forced.push_back(24'h001002);
      forced.push_back(24'h00C00D);
      repeat (127) forced.push_back(24'h003004);
      forced.push_back(24'hFFF005);
      forced.push_back(24'h00A00B);
      start_run(2, 1'b0);
      b = 0;
      while (stop_cnt < 2 && b < 5000) begin
         tick();
         b++;
      end
      if (stop_cnt < 2) fail("bnd_stop_timeout");
      repeat (3) tick();
      check("bnd_forced_left", forced.size(), 0);
      check("bnd_writes", wlog.size(), 512);
      if (wlog.size() >= 512) begin
         check("bnd_p0_254", {wlog[254].addr, wlog[254].data}, {12'h0FE, 12'h00D});
         check("bnd_p0_255", {wlog[255].addr, wlog[255].data}, {12'h0FF, 12'h00C});
         check("bnd_p1_254", {wlog[510].addr, wlog[510].data}, {12'h1FE, 12'h005});
         check("bnd_p1_255", {wlog[511].addr, wlog[511].data}, {12'h1FF, 12'h00B});
      end
      auto_mode = 1'b1;
      finish_run(2);

      // Seed byte ordering, both orientations, plus a stalled k=4 run.
      stall_pct = 30;
      start_run(3, 1'b0);
      finish_run(3);
      start_run(3, 1'b1);
      finish_run(3);
      stall_pct = 40;
      start_run(4, 1'b0);
      finish_run(4);

      // Asynchronous reset mid-squeeze, then a clean restart.
      stall_pct = 10;
      start_run(2, 1'b1);
      b = 0;
      while (wlog.size() < 50 && b < 3000) begin
         tick();
         b++;
      end
      if (wlog.size() < 50) fail("rst_prewrites_timeout");
      #2 rst = 1'b1;
      exp_q.delete();
      forced.delete();
      #1;
      check("rst_outputs", {bus.busy_o, bus.done_o, bus.xof_start_o, bus.xof_b32_o,
                            bus.xof_b33_o, bus.xof_ready_o, bus.xof_stop_o, bus.wr_en_o,
                            bus.wr_addr_o, bus.wr_data_o}, 64'd0);
      nlog = wlog.size();
      repeat (4) tick();
      check("rst_no_writes", wlog.size(), nlog);
      rst = 1'b0;
      bus.xof_ack_i = 1'b0;
      tick();
      start_run(2, 1'b0);
      repeat (40) tick();
      bus.k_i = 3'd3;
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      finish_run(2);
      if (wlog.size() != 0) check("restart_first_addr", wlog[0].addr, 12'h000);

      // Illegal ranks leave the block idle.
      auto_mode = 1'b0;
      for (int unsigned kk = 0; kk < 8; kk++) begin
         if (kk < 2 || kk > 4) begin
            bus.k_i = 3'(kk);
            bus.start_i = 1'b1;
            tick();
            bus.start_i = 1'b0;
            repeat (3) tick();
            check("illegal_k_busy", bus.busy_o, 0);
            check("illegal_k_xstart", bus.xof_start_o, 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ml_kem_matgen_ctrl.md
Name: ml_kem_matgen_ctrl

Overview:
- Sequencer for generation of the ML-KEM public matrix A (k x k NTT-domain polynomials) from seed rho.
- Per polynomial: starts the shared SHAKE128 XOF on rho||b32||b33, consumes 24-bit squeeze words, and runs the FIPS 203 SampleNTT rejection parse.
- Writes accepted 12-bit coefficients into the polynomial RAM.
- Sits between the ML_KEM top-level mode control and the Keccak core / poly RAM.

Parameters:
- Q, 3329, modulus; a candidate is accepted iff it is < Q.
- N, 256, coefficients per polynomial.
- PIDX_W, 4, width of polynomial index (max k*k = 16).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  one-cycle pulse; begins generation (ignored unless IDLE).
- k_i  in  3  rank k, legal 2/3/4; sampled at start_i.
- transpose_i  in  1  0: seed rho||j||i for A[i][j]; 1: rho||i||j. Sampled at start_i.
- busy_o  out  1  high from the cycle after accepted start_i until DONE.
- done_o  out  1  one-cycle pulse when the last coefficient of the last polynomial is written.
- xof_start_o  out  1  level request to (re)init the XOF absorb; held until xof_ack_i.
- xof_b32_o  out  8  first appended seed byte.
- xof_b33_o  out  8  second appended seed byte.
- xof_ack_i  in  1  XOF accepted the start; squeeze stream follows.
- xof_valid_i  in  1  squeeze word valid.
- xof_data_i  in  24  three bytes; b0=[7:0], b1=[15:8], b2=[23:16].
- xof_ready_o  out  1  word accepted when xof_valid_i && xof_ready_o.
- xof_stop_o  out  1  one-cycle pulse: current XOF stream no longer needed.
- wr_en_o  out  1  coefficient write strobe.
- wr_addr_o  out  PIDX_W+8  {poly_idx, coeff_idx}; poly_idx = i*k + j.
- wr_data_o  out  12  coefficient.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters i, j, coeff_idx and hold register cleared. rst_i mid-operation aborts immediately; no further writes.
- States:
  - IDLE: start_i with legal k_i -> SEED, i=j=0. Illegal k_i (0, 1, >4) -> start ignored, stays IDLE.
  - SEED: xof_start_o=1; seed bytes driven from i/j and transpose_i, stable while xof_start_o is high. xof_ack_i -> SQUEEZE, coeff_idx=0.
  - SQUEEZE: xof_ready_o=1 unless the hold register is full.
  - FLUSH: writes the held coefficient, xof_ready_o=0.
  - NEXT: xof_stop_o pulse. Advance j; on j==k-1 wrap j=0, i++. If the last polynomial is finished -> DONE, else -> SEED.
  - DONE: done_o pulse, busy_o drops the same cycle, -> IDLE.
- Parse per accepted word:
  - d1 = b0 + 256*(b1 & 0xF); d2 = (b1>>4) + 16*b2.
  - Accept d1 if d1<Q; accept d2 if d2<Q and coeff_idx has not reached N after d1.
- Write timing and hold register:
  - Writes are registered: wr_en_o and data appear the cycle after the word handshake.
  - If d1 and d2 are both accepted, d1 is written first and d2 goes to the one-entry hold register.
  - Next cycle -> FLUSH writes d2, then returns to SQUEEZE (or NEXT if coeff_idx reached N).
  - If only one candidate is accepted, write it directly. Both rejected: no write.
- coeff_idx increments per write.
  - If d1 is coefficient 255, d2 is discarded and the state goes to NEXT.
  - After the 256th write, xof_ready_o stays 0 and remaining words are ignored.
- Exactly N writes per polynomial, k*k polynomials, addresses strictly increasing.
- start_i while busy_o: ignored.
- xof_valid_i outside SQUEEZE: ignored.

Test Plan:
- k_i=2, transpose_i=0, start pulse; first word 24'h8B5AAB -> writes addr 0 data 0xAAB, then addr 1 data 0x8B5 (via FLUSH), with xof_ready_o low exactly one cycle.
- Word 24'hFFFD01 (d1=3329, d2=4095) -> no write, coeff_idx unchanged; word 24'h000D00 (d1=3328 accepted, d2=0 accepted) -> two writes 0xD00, 0x000.
- Seed bytes: k=3, transpose_i=0 -> (b32,b33) sequence (0,0),(1,0),(2,0),(0,1)...(2,2); transpose_i=1 -> swapped. 9 xof_stop_o pulses, done_o once, wr_addr last = {8,255}.
- Boundary: 254 coefficients written, then word giving two accepts -> writes coeffs 254/255; next word both accepted at idx 255 -> only d1 written, d2 dropped, xof_stop_o pulses, no 257th write.
- Random xof_valid_i stalls plus k=4 full run -> exactly 4096 writes, all < 3329, matching the software SampleNTT model.
- rst_i asserted mid-SQUEEZE -> all outputs 0 asynchronously; new start_i after release restarts from poly 0, coeff 0. start_i while busy and k_i=5 at start -> ignored.
